// File: rtl/cselector_sync.sv
`default_nettype none
// ============================================================================
// Module      : cselector_sync
// Description : Token selector / multicast fan-out with join.
//               An upstream token (i_drive + i_select mask) is launched as a
//               one-cycle o_driveNext pulse on every selected port. The block
//               then waits for i_freeNext releases (all selected ports when
//               JOIN_ALL=1, any one when JOIN_ALL=0), or for an optional
//               timeout, and returns a one-cycle o_free pulse upstream.
//               One token can be held in a pending slot while busy.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_select, i_drive   - upstream token request and port mask
//               o_free              - upstream token release pulse
//               o_driveNext         - per-port token pulse
//               i_freeNext          - per-port release pulse
//               i_timeout_limit     - WAIT cycle limit, 0 disables timeout
//               i_clr_err           - clears the sticky error flags
//               o_busy              - FSM active or pending slot full
//               o_err_nosel, o_err_overrun, o_timeout - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module cselector_sync #(
  parameter int NUM_PORTS = 8,
  parameter int JOIN_ALL  = 1,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_select,
  input  logic                 i_drive,
  output logic                 o_free,
  output logic [NUM_PORTS-1:0] o_driveNext,
  input  logic [NUM_PORTS-1:0] i_freeNext,
  input  logic [TIMEOUT_W-1:0] i_timeout_limit,
  input  logic                 i_clr_err,
  output logic                 o_busy,
  output logic                 o_err_nosel,
  output logic                 o_err_overrun,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] C_CNT_ONE = TIMEOUT_W'(1);

  state_t                 r_state_q;
  logic [NUM_PORTS-1:0]   r_sel_q;
  logic [NUM_PORTS-1:0]   r_got_q;
  logic                   r_pend_vld_q;
  logic [NUM_PORTS-1:0]   r_pend_mask_q;
  logic [TIMEOUT_W-1:0]   r_cnt_q;
  logic [NUM_PORTS-1:0]   r_drive_q;
  logic                   r_free_q;
  logic                   r_err_nosel_q;
  logic                   r_err_overrun_q;
  logic                   r_timeout_q;

  logic                   w_launch;
  logic [NUM_PORTS-1:0]   w_launch_mask;
  logic [NUM_PORTS-1:0]   w_free_hit;
  logic [NUM_PORTS-1:0]   w_got_all;
  logic                   w_complete;
  logic [TIMEOUT_W-1:0]   w_cnt_inc;
  logic                   w_timeout_hit;
  logic                   w_nosel_evt;
  logic                   w_overrun_evt;
  logic                   w_timeout_evt;

  always_comb begin
    // The pending token always has precedence over a fresh request so
    // tokens leave in arrival order.
    w_launch      = (r_state_q == ST_IDLE) && (r_pend_vld_q || i_drive);
    w_launch_mask = r_pend_vld_q ? r_pend_mask_q : i_select;

    w_free_hit = i_freeNext & r_sel_q;
    w_got_all  = r_got_q | w_free_hit;
    if (JOIN_ALL != 0) begin
      w_complete = (w_got_all == r_sel_q);
    end else begin
      w_complete = (w_free_hit != '0) || (r_got_q != '0);
    end

    // Saturating increment; the compare uses the post-increment value so
    // a limit of N aborts after exactly N WAIT cycles.
    w_cnt_inc     = (&r_cnt_q) ? r_cnt_q : (r_cnt_q + C_CNT_ONE);
    w_timeout_hit = (i_timeout_limit != '0) && (w_cnt_inc == i_timeout_limit);

    w_nosel_evt   = w_launch && (w_launch_mask == '0);
    w_overrun_evt = i_drive && (r_state_q != ST_IDLE) && r_pend_vld_q;
    // Completion wins over a same-cycle timeout.
    w_timeout_evt = (r_state_q == ST_WAIT) && !w_complete && w_timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q       <= ST_IDLE;
      r_sel_q         <= '0;
      r_got_q         <= '0;
      r_pend_vld_q    <= 1'b0;
      r_pend_mask_q   <= '0;
      r_cnt_q         <= '0;
      r_drive_q       <= '0;
      r_free_q        <= 1'b0;
      r_err_nosel_q   <= 1'b0;
      r_err_overrun_q <= 1'b0;
      r_timeout_q     <= 1'b0;
    end else begin
      // Output pulses default low; each is raised for exactly one cycle.
      r_drive_q <= '0;
      r_free_q  <= 1'b0;

      case (r_state_q)
        ST_IDLE: begin
          if (w_launch) begin
            r_sel_q <= w_launch_mask;
            r_got_q <= '0;
            if (w_launch_mask == '0) begin
              // Nothing to fan out, but upstream still needs its release.
              r_state_q <= ST_DONE;
            end else begin
              r_state_q <= ST_FIRE;
              r_drive_q <= w_launch_mask;
            end
          end
        end
        ST_FIRE: begin
          r_got_q   <= w_got_all;
          r_cnt_q   <= '0;
          r_state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          r_got_q <= w_got_all;
          r_cnt_q <= w_cnt_inc;
          if (w_complete || w_timeout_hit) begin
            r_state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_free_q  <= 1'b1;
          r_state_q <= ST_IDLE;
        end
        default: begin
          r_state_q <= ST_IDLE;
        end
      endcase

      // Single-entry pending slot.
      if (r_state_q == ST_IDLE) begin
        if (r_pend_vld_q) begin
          if (i_drive) begin
            // Pending token launches now; the new one takes its place.
            r_pend_mask_q <= i_select;
          end else begin
            r_pend_vld_q <= 1'b0;
          end
        end
      end else if (i_drive && !r_pend_vld_q) begin
        r_pend_vld_q  <= 1'b1;
        r_pend_mask_q <= i_select;
      end

      // Sticky flags: a same-cycle event beats the clear.
      r_err_nosel_q   <= (r_err_nosel_q   & ~i_clr_err) | w_nosel_evt;
      r_err_overrun_q <= (r_err_overrun_q & ~i_clr_err) | w_overrun_evt;
      r_timeout_q     <= (r_timeout_q     & ~i_clr_err) | w_timeout_evt;
    end
  end

  assign o_driveNext   = r_drive_q;
  assign o_free        = r_free_q;
  assign o_busy        = (r_state_q != ST_IDLE) || r_pend_vld_q;
  assign o_err_nosel   = r_err_nosel_q;
  assign o_err_overrun = r_err_overrun_q;
  assign o_timeout     = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cselector_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_cselector_sync
// Description : Self-checking bench for cselector_sync. Directed stimulus
//               pushes expected o_driveNext / o_free events (cycle + value)
//               into queues; a monitor pops and compares whenever a DUT
//               presents a pulse. Two instances cover JOIN_ALL=1 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cselector_sync;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [7:0] i_select;
  logic       i_drive;
  logic       i_drive0;
  logic [7:0] i_freeNext;
  logic [7:0] i_timeout_limit;
  logic       i_clr_err;

  logic       o_free,  o_busy,  o_err_nosel,  o_err_overrun,  o_timeout;
  logic [7:0] o_driveNext;
  logic       o0_free, o0_busy, o0_err_nosel, o0_err_overrun, o0_timeout;
  logic [7:0] o0_driveNext;

  int cyc;
  int checks;
  int errors;

  ev_t q_drv[$];
  ev_t q_free[$];
  ev_t q0_drv[$];
  ev_t q0_free[$];

  cselector_sync #(.NUM_PORTS(8), .JOIN_ALL(1), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .i_select(i_select), .i_drive(i_drive),
    .o_free(o_free), .o_driveNext(o_driveNext), .i_freeNext(i_freeNext),
    .i_timeout_limit(i_timeout_limit), .i_clr_err(i_clr_err),
    .o_busy(o_busy), .o_err_nosel(o_err_nosel),
    .o_err_overrun(o_err_overrun), .o_timeout(o_timeout)
  );

  cselector_sync #(.NUM_PORTS(8), .JOIN_ALL(0), .TIMEOUT_W(8)) dut0 (
    .clk(clk), .rst(rst), .i_select(i_select), .i_drive(i_drive0),
    .o_free(o0_free), .o_driveNext(o0_driveNext), .i_freeNext(i_freeNext),
    .i_timeout_limit(i_timeout_limit), .i_clr_err(i_clr_err),
    .o_busy(o0_busy), .o_err_nosel(o0_err_nosel),
    .o_err_overrun(o0_err_overrun), .o_timeout(o0_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(inout ev_t q[$], input int c, input logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  // Advance to the falling edge of cycle k, clearing single-cycle pulses.
  task automatic at_cycle(input int k);
    while (cyc < k) begin
      @(negedge clk);
      i_drive    = 1'b0;
      i_drive0   = 1'b0;
      i_freeNext = 8'h00;
      i_clr_err  = 1'b0;
    end
  endtask

  task automatic mon_pulse(input string name, inout ev_t q[$], input logic [7:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: got %0h at cycle %0d expected no pulse", name, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL %s: got %0h at cycle %0d expected %0h at cycle %0d",
                 name, v, cyc, e.val, e.cyc);
      end
    end
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_driveNext != 8'h00) mon_pulse("drive",  q_drv,   o_driveNext);
      if (o_free)               mon_pulse("free",   q_free,  8'h01);
      if (o0_driveNext != 8'h00) mon_pulse("drive0", q0_drv,  o0_driveNext);
      if (o0_free)               mon_pulse("free0",  q0_free, 8'h01);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic run_unicast();
    int t;
    t = cyc;
    i_select = 8'h04;
    i_drive  = 1'b1;
    push(q_drv,  t + 1, 8'h04);
    push(q_free, t + 6, 8'h01);
    at_cycle(t + 2);
    chk("unicast_busy", {31'd0, o_busy}, 32'd1);
    at_cycle(t + 4);
    i_freeNext = 8'h04;
    at_cycle(t + 8);
    chk("unicast_idle", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int t;
    cyc = 0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_select = 8'h00;
    i_drive = 1'b0;
    i_drive0 = 1'b0;
    i_freeNext = 8'h00;
    i_timeout_limit = 8'h00;
    i_clr_err = 1'b0;

    // Reset state
    @(negedge clk);
    at_cycle(3);
    rst = 1'b0;
    chk("rst_drive",   {24'd0, o_driveNext}, 32'd0);
    chk("rst_free",    {31'd0, o_free}, 32'd0);
    chk("rst_busy",    {31'd0, o_busy}, 32'd0);
    chk("rst_nosel",   {31'd0, o_err_nosel}, 32'd0);
    chk("rst_overrun", {31'd0, o_err_overrun}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    at_cycle(5);

    // Unicast
    run_unicast();

    // Multicast join, both JOIN_ALL flavours on the same stimulus
    t = cyc;
    i_select = 8'h81;
    i_drive  = 1'b1;
    i_drive0 = 1'b1;
    push(q_drv,   t + 1, 8'h81);
    push(q_free,  t + 9, 8'h01);
    push(q0_drv,  t + 1, 8'h81);
    push(q0_free, t + 5, 8'h01);
    at_cycle(t + 3);
    i_freeNext = 8'h01;
    at_cycle(t + 7);
    i_freeNext = 8'h80;
    at_cycle(t + 11);

    // Zero mask
    t = cyc;
    i_select = 8'h00;
    i_drive  = 1'b1;
    push(q_free, t + 2, 8'h01);
    at_cycle(t + 1);
    chk("nosel_set", {31'd0, o_err_nosel}, 32'd1);
    at_cycle(t + 3);
    i_clr_err = 1'b1;
    at_cycle(t + 4);
    chk("nosel_clr", {31'd0, o_err_nosel}, 32'd0);
    at_cycle(t + 6);

    // Back-to-back overrun: A launches, B waits pending, C is dropped
    t = cyc;
    i_select = 8'h02;
    i_drive  = 1'b1;
    push(q_drv,  t + 1,  8'h02);
    push(q_free, t + 8,  8'h01);
    push(q_drv,  t + 9,  8'h10);
    push(q_free, t + 13, 8'h01);
    for (int k = t + 1; k <= t + 13; k++) begin
      at_cycle(k);
      if (k == t + 3) begin i_select = 8'h10; i_drive = 1'b1; end
      if (k == t + 4) begin i_select = 8'h20; i_drive = 1'b1; end
      if (k == t + 6) i_freeNext = 8'h02;
      if (k == t + 11) i_freeNext = 8'h10;
      if (k == t + 5) chk("overrun_set", {31'd0, o_err_overrun}, 32'd1);
      chk("overrun_busy", {31'd0, o_busy}, (k <= t + 12) ? 32'd1 : 32'd0);
    end
    at_cycle(t + 14);
    i_clr_err = 1'b1;
    at_cycle(t + 15);
    chk("overrun_clr", {31'd0, o_err_overrun}, 32'd0);
    at_cycle(t + 17);

    // Timeout: limit 5, WAIT spans t+2..t+6, abort visible at t+7
    t = cyc;
    i_timeout_limit = 8'd5;
    i_select = 8'h01;
    i_drive  = 1'b1;
    push(q_drv,  t + 1, 8'h01);
    push(q_free, t + 8, 8'h01);
    at_cycle(t + 6);
    chk("timeout_early", {31'd0, o_timeout}, 32'd0);
    at_cycle(t + 7);
    chk("timeout_set", {31'd0, o_timeout}, 32'd1);
    at_cycle(t + 9);
    i_clr_err = 1'b1;
    at_cycle(t + 10);
    chk("timeout_clr", {31'd0, o_timeout}, 32'd0);
    at_cycle(t + 12);

    // Completion and timeout in the same cycle: completion wins
    t = cyc;
    i_select = 8'h01;
    i_drive  = 1'b1;
    push(q_drv,  t + 1, 8'h01);
    push(q_free, t + 8, 8'h01);
    at_cycle(t + 6);
    i_freeNext = 8'h01;
    at_cycle(t + 9);
    chk("timeout_priority", {31'd0, o_timeout}, 32'd0);
    i_timeout_limit = 8'd0;
    at_cycle(t + 11);

    // Reset in the middle of WAIT: token is abandoned, no late o_free
    t = cyc;
    i_select = 8'h04;
    i_drive  = 1'b1;
    push(q_drv, t + 1, 8'h04);
    at_cycle(t + 3);
    rst = 1'b1;
    at_cycle(t + 4);
    rst = 1'b0;
    chk("midrst_busy",  {31'd0, o_busy}, 32'd0);
    chk("midrst_free",  {31'd0, o_free}, 32'd0);
    chk("midrst_drive", {24'd0, o_driveNext}, 32'd0);
    at_cycle(t + 12);
    run_unicast();
    at_cycle(cyc + 4);

    // Every expected pulse must have been seen
    chk("drv_left",   q_drv.size(),   32'd0);
    chk("free_left",  q_free.size(),  32'd0);
    chk("drv0_left",  q0_drv.size(),  32'd0);
    chk("free0_left", q0_free.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
